// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller and the floor-request register.
package elevator_pkg;

  localparam int DEF_NFL  = 8;
  localparam int DEF_FL_W = 3;

  // Car FSM states; also exported on the debug port of the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2,
    ST_DOOR = 2'd3
  } car_state_e;

  // Direction of travel remembered between moves (SCAN scheduling).
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // One-hot floor mask at the default building size.
  function automatic logic [DEF_NFL-1:0] onehot(input logic [DEF_FL_W-1:0] fl);
    logic [DEF_NFL-1:0] v;
    v     = '0;
    v[fl] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module cyc_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: SCAN scheduling over the pending-call vector, floor-by-floor
// travel, door dwell with hold-on-recall, and per-floor clear pulses.
//
// Request-register contract: pend is a level per floor. When the car serves floor f it
// raises off[f] for exactly one cycle; the request register drops pend[f] on the clock
// edge that sees off[f]. While off is high, pend at the served floor is therefore stale
// and is ignored; a pend[f] seen at an open door while off is low is a fresh re-call.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NFL      = DEF_NFL,
  parameter int FL_W     = DEF_FL_W,
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NFL-1:0]  pend,
  output logic [NFL-1:0]  off,
  output logic [FL_W-1:0] cur_fl,
  output logic            up,
  output logic            down,
  output logic            door_open,
  output car_state_e      dbg_state
);

  localparam int            MAXC    = (MOVE_CYC > DOOR_CYC) ? MOVE_CYC : DOOR_CYC;
  localparam int            TW      = $clog2(MAXC + 1);
  localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_CYC - 1);
  localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYC - 1);

  car_state_e      r_state;
  logic            r_dir;
  logic [FL_W-1:0] r_cur_fl;
  logic            r_arr;
  logic [NFL-1:0]  r_off;
  logic            r_up;
  logic            r_down;
  logic            r_door;

  logic [NFL-1:0]  w_here_oh;
  logic [NFL-1:0]  w_below_mask;
  logic [NFL-1:0]  w_above_mask;
  logic            w_here;
  logic            w_above;
  logic            w_below;
  logic            w_ahead;
  logic            w_behind;
  logic            w_off_busy;
  car_state_e      w_pk_state;
  logic            w_pk_dir;
  logic            w_pk_move;
  car_state_e      w_state_nx;
  logic            w_dir_nx;
  logic [FL_W-1:0] w_fl_nx;
  logic            w_arr_nx;
  logic            w_mv_load;
  logic            w_dr_load;
  logic [NFL-1:0]  w_off_nx;
  logic            w_mv_en;
  logic            w_dr_en;
  logic            w_mv_tc;
  logic            w_dr_tc;

  // Floor masks relative to the current floor; at the top floor the above mask is
  // empty and at floor 0 the below mask is empty, so travel never leaves 0..NFL-1.
  assign w_here_oh    = NFL'(1) << r_cur_fl;
  assign w_below_mask = w_here_oh - NFL'(1);
  assign w_above_mask = ~(w_below_mask | w_here_oh);
  assign w_here       = |(pend & w_here_oh);
  assign w_above      = |(pend & w_above_mask);
  assign w_below      = |(pend & w_below_mask);
  assign w_ahead      = (r_dir == DIR_UP) ? w_above : w_below;
  assign w_behind     = (r_dir == DIR_UP) ? w_below : w_above;
  assign w_off_busy   = |r_off;
  assign w_pk_move    = (w_pk_state != ST_IDLE);

  assign w_mv_en = (r_state == ST_UP) || (r_state == ST_DN);
  assign w_dr_en = (r_state == ST_DOOR);

  cyc_timer #(.W(TW)) u_move_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mv_load),
    .i_load_val (MOVE_LD),
    .i_en       (w_mv_en),
    .o_tc       (w_mv_tc)
  );

  cyc_timer #(.W(TW)) u_door_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dr_load),
    .i_load_val (DOOR_LD),
    .i_en       (w_dr_en),
    .o_tc       (w_dr_tc)
  );

  // Movement choice when the car is free to pick: keep direction, else reverse, else rest.
  always_comb begin
    w_pk_state = ST_IDLE;
    w_pk_dir   = r_dir;
    if (w_ahead) begin
      w_pk_state = (r_dir == DIR_UP) ? ST_UP : ST_DN;
    end else if (w_behind) begin
      w_pk_dir   = ~r_dir;
      w_pk_state = (r_dir == DIR_UP) ? ST_DN : ST_UP;
    end
  end

  // Next-state logic: serve here first, travel one floor per timer period, hold the door.
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_fl_nx    = r_cur_fl;
    w_arr_nx   = 1'b0;
    w_mv_load  = 1'b0;
    w_dr_load  = 1'b0;
    w_off_nx   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_here) begin
          w_state_nx = ST_DOOR;
          w_dr_load  = 1'b1;
          w_off_nx   = w_here_oh;
        end else begin
          w_state_nx = w_pk_state;
          w_dir_nx   = w_pk_dir;
          w_mv_load  = w_pk_move;
        end
      end
      ST_UP, ST_DN: begin
        // pend is only looked at in the cycle right after reaching a new floor.
        if (r_arr && w_here) begin
          w_state_nx = ST_DOOR;
          w_dr_load  = 1'b1;
          w_off_nx   = w_here_oh;
        end else if (r_arr && !w_ahead) begin
          w_state_nx = w_pk_state;
          w_dir_nx   = w_pk_dir;
          w_mv_load  = w_pk_move;
        end else if (w_mv_tc) begin
          w_fl_nx   = (r_dir == DIR_UP) ? r_cur_fl + FL_W'(1) : r_cur_fl - FL_W'(1);
          w_mv_load = 1'b1;
          w_arr_nx  = 1'b1;
        end
      end
      ST_DOOR: begin
        if (w_here && !w_off_busy) begin
          // Re-call at the open door: clear it again and restart the dwell.
          w_off_nx  = w_here_oh;
          w_dr_load = 1'b1;
        end else if (w_dr_tc) begin
          w_state_nx = w_pk_state;
          w_dir_nx   = w_pk_dir;
          w_mv_load  = w_pk_move;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, position and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dir    <= DIR_UP;
      r_cur_fl <= '0;
      r_arr    <= 1'b0;
      r_off    <= '0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_door   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_dir    <= w_dir_nx;
      r_cur_fl <= w_fl_nx;
      r_arr    <= w_arr_nx;
      r_off    <= w_off_nx;
      r_up     <= (w_state_nx == ST_UP);
      r_down   <= (w_state_nx == ST_DN);
      r_door   <= (w_state_nx == ST_DOOR);
    end
  end

  assign off       = r_off;
  assign cur_fl    = r_cur_fl;
  assign up        = r_up;
  assign down      = r_down;
  assign door_open = r_door;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: directed scenarios plus random calls, every cycle
// compared with a behavioural car model; the bench also plays the request register.
module tb_elevator_car_ctrl;
  import elevator_pkg::*;

  localparam int NFL      = 8;
  localparam int FL_W     = 3;
  localparam int MOVE_CYC = 4;
  localparam int DOOR_CYC = 6;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NFL-1:0]  pend;
  logic [NFL-1:0]  off;
  logic [FL_W-1:0] cur_fl;
  logic            up;
  logic            down;
  logic            door_open;
  car_state_e      dbg_state;

  elevator_car_ctrl #(
    .NFL      (NFL),
    .FL_W     (FL_W),
    .MOVE_CYC (MOVE_CYC),
    .DOOR_CYC (DOOR_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pend      (pend),
    .off       (off),
    .cur_fl    (cur_fl),
    .up        (up),
    .down      (down),
    .door_open (door_open),
    .dbg_state (dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The car is described by what it is doing (resting, travelling, dwelling), where it
  // is, which way it is heading and how long the current leg or dwell has run.
  int             m_mode;
  int             m_dir;
  int             m_fl;
  int             m_elapsed;
  bit             m_arrived;
  int             m_door_left;
  logic [NFL-1:0] m_off;

  function automatic bit calls_toward(input int f, input int d, input logic [NFL-1:0] p);
    for (int g = 0; g < NFL; g++) begin
      if (((g - f) * d > 0) && p[g]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_dir = 1; m_fl = 0; m_elapsed = 0;
    m_arrived = 1'b0; m_door_left = 0; m_off = '0;
  endtask

  task automatic open_door();
    m_mode = M_DOOR;
    m_door_left = DOOR_CYC;
    m_off = '0;
    m_off[m_fl] = 1'b1;
  endtask

  task automatic choose(input logic [NFL-1:0] p, input bit allow_here);
    if (allow_here && p[m_fl]) begin
      open_door();
    end else if (calls_toward(m_fl, m_dir, p)) begin
      m_mode = M_MOVE; m_elapsed = 0; m_arrived = 1'b0;
    end else if (calls_toward(m_fl, -m_dir, p)) begin
      m_dir = -m_dir; m_mode = M_MOVE; m_elapsed = 0; m_arrived = 1'b0;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  // Advance the model across one rising edge that sees call vector p.
  task automatic model_step(input logic [NFL-1:0] p);
    logic [NFL-1:0] prev_off;
    bit go;
    prev_off = m_off;
    m_off = '0;
    case (m_mode)
      M_IDLE: choose(p, 1'b1);
      M_MOVE: begin
        go = 1'b1;
        if (m_arrived && (p[m_fl] || !calls_toward(m_fl, m_dir, p))) begin
          choose(p, 1'b1);
          go = 1'b0;
        end
        if (go) begin
          m_arrived = 1'b0;
          m_elapsed++;
          if (m_elapsed == MOVE_CYC) begin
            m_fl = m_fl + m_dir;
            m_elapsed = 0;
            m_arrived = 1'b1;
          end
        end
      end
      default: begin
        if (p[m_fl] && (prev_off == '0)) begin
          m_door_left = DOOR_CYC;
          m_off[m_fl] = 1'b1;
        end else begin
          m_door_left--;
          if (m_door_left == 0) choose(p, 1'b0);
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("cur_fl", 32'(cur_fl), 32'(m_fl));
    chk("up", 32'(up), 32'((m_mode == M_MOVE) && (m_dir > 0)));
    chk("down", 32'(down), 32'((m_mode == M_MOVE) && (m_dir < 0)));
    chk("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
    chk("off", 32'(off), 32'(m_off));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: the request register drops served calls and latches new ones, then the
  // edge happens and the outputs are compared at the following falling edge.
  task automatic cycle(input logic [NFL-1:0] new_calls);
    pend = (pend & ~m_off) | new_calls;
    model_step(pend);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle('0);
  endtask

  task automatic run_until_off(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; (i < max_cyc) && !seen; i++) begin
      cycle('0);
      if (off != '0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_door;
    bit off_seen;
    logic [NFL-1:0] nc;

    // Reset held with every floor calling.
    rst = 1'b1;
    pend = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cur_fl", 32'(cur_fl), 32'd0);
    chk("rst_off", 32'(off), 32'd0);
    chk("rst_up", 32'(up), 32'd0);
    chk("rst_down", 32'(down), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    pend = '0;
    rst = 1'b0;

    // Asynchronous reset in the middle of a move.
    cycle(8'h80);
    run(5);
    chk("pre_rst_up", 32'(up), 32'd1);
    chk("pre_rst_fl", 32'(cur_fl), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_cur_fl", 32'(cur_fl), 32'd0);
    chk("async_up", 32'(up), 32'd0);
    chk("async_down", 32'(down), 32'd0);
    chk("async_door", 32'(door_open), 32'd0);
    chk("async_off", 32'(off), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pend = '0;
    model_reset();

    // Call at the resting floor.
    cycle(8'h01);
    chk("t2_door", 32'(door_open), 32'd1);
    chk("t2_off", 32'(off), 32'h01);
    n_door = 1;
    cycle('0);
    chk("t2_off_once", 32'(off), 32'd0);
    n_door += int'(door_open);
    for (int i = 0; i < 8; i++) begin
      cycle('0);
      n_door += int'(door_open);
    end
    chk("t2_door_len", 32'(n_door), 32'd6);

    // Travel up two floors.
    cycle(8'h04);
    chk("t3_up", 32'(up), 32'd1);
    run(4);
    chk("t3_fl1", 32'(cur_fl), 32'd1);
    run(4);
    chk("t3_fl2", 32'(cur_fl), 32'd2);
    run(1);
    chk("t3_off", 32'(off), 32'h04);
    chk("t3_door", 32'(door_open), 32'd1);
    run(8);

    // Calls on both sides: ahead first, then reverse.
    cycle(8'h0A);
    chk("t4_up", 32'(up), 32'd1);
    run_until_off(20, "t4_reach3");
    chk("t4_off3", 32'(off), 32'h08);
    chk("t4_fl3", 32'(cur_fl), 32'd3);
    run(6);
    chk("t4_down", 32'(down), 32'd1);
    run_until_off(20, "t4_reach1");
    chk("t4_off1", 32'(off), 32'h02);
    chk("t4_fl1", 32'(cur_fl), 32'd1);
    run(8);

    // Call withdrawn mid-travel.
    cycle(8'h01);
    run_until_off(20, "t5_reach0");
    chk("t5_off0", 32'(off), 32'h01);
    run(8);
    cycle(8'h20);
    run(5);
    pend = '0;
    off_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle('0);
      if (off != '0) off_seen = 1'b1;
    end
    chk("t5_fl", 32'(cur_fl), 32'd2);
    chk("t5_up", 32'(up), 32'd0);
    chk("t5_door", 32'(door_open), 32'd0);
    chk("t5_no_off", 32'(off_seen), 32'd0);

    // Re-call at an open door.
    cycle(8'h10);
    run_until_off(20, "t6_reach4");
    chk("t6_off", 32'(off), 32'h10);
    chk("t6_fl", 32'(cur_fl), 32'd4);
    cycle('0);
    cycle('0);
    cycle(8'h10);
    chk("t6_recall_off", 32'(off), 32'h10);
    n_door = int'(door_open);
    for (int i = 0; i < 8; i++) begin
      cycle('0);
      n_door += int'(door_open);
    end
    chk("t6_hold_len", 32'(n_door), 32'd6);

    // Random traffic with occasional withdrawals.
    for (int i = 0; i < 3000; i++) begin
      nc = '0;
      if ($urandom_range(0, 5) == 0) nc[$urandom_range(0, NFL - 1)] = 1'b1;
      if ($urandom_range(0, 39) == 0) pend[$urandom_range(0, NFL - 1)] = 1'b0;
      cycle(nc);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Run-time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
